// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and defaults for the unified memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} arb_owner_t;
  localparam int ARB_STARVE_LIMIT = 4;
  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 64;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-macro signals bundled for the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int MASK_W = DATA_W / 8
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic [ADDR_W-1:0] dm_addr;
  logic [MASK_W-1:0] dm_wmask;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0] mem_w_mask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, dm_req, dm_addr, dm_wmask, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_addr, mem_w_mask, mem_wdata
  );
  modport master (
    output if_req, if_addr, dm_req, dm_addr, dm_wmask, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_addr, mem_w_mask, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port byte-masked memory between fetch (IF) and load/store (DM)
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side: if_* fetch port, dm_* data port, mem_* memory macro port
//   Grants are combinational from requests and the DM streak; read data returns one cycle
//   after a grant, qualified by the owner's rvalid. DM wins contention until it has won
//   STARVE_LIMIT times in a row while IF waited, then IF is forced.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input logic             clk,
  input logic             rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [SW-1:0] streak;
  arb_owner_t    rsp_owner;
  logic          if_win;
  assign if_win = bus.if_req && (!bus.dm_req || streak == LIMIT);
  // grants are held low while reset is asserted so nothing reaches the memory
  assign bus.if_gnt     = rst_n && if_win;
  assign bus.dm_gnt     = rst_n && bus.dm_req && !if_win;
  assign bus.mem_addr   = bus.dm_gnt ? bus.dm_addr : bus.if_addr;
  assign bus.mem_w_mask = bus.dm_gnt ? bus.dm_wmask : '0;
  assign bus.mem_wdata  = bus.dm_wdata;
  assign bus.if_rvalid  = rsp_owner == OWN_IF;
  assign bus.dm_rvalid  = rsp_owner == OWN_DM;
  assign bus.if_rdata   = bus.mem_rdata;
  assign bus.dm_rdata   = bus.mem_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner <= OWN_NONE;
      streak    <= '0;
    end else begin
      rsp_owner <= bus.if_gnt ? OWN_IF : (bus.dm_gnt && bus.dm_wmask == '0) ? OWN_DM : OWN_NONE;
      streak    <= (!bus.if_req || bus.if_gnt) ? '0 :
                   (bus.dm_gnt && streak != LIMIT) ? streak + SW'(1) : streak;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus against a memory macro model and a cycle-level reference model
module tb_mem_port_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [63:0] mem [8192];
  logic [63:0] ref_mem [8192];
  int streak_m = 0;
  bit pend_if = 0;
  bit pend_dm = 0;
  logic [63:0] pend_data = '0;
  string pat = "";
  always #5 clk = ~clk;
  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [63:0] word(input int n);
    return {32'hA000_0000 + 32'(n), 32'h5000_0000 + 32'(n)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory macro: byte-masked write, write-first registered read
  always @(posedge clk) begin
    logic [63:0] w;
    w = mem[bus.mem_addr[15:3]];
    for (int b = 0; b < 8; b++)
      if (bus.mem_w_mask[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
    mem[bus.mem_addr[15:3]] <= w;
    bus.mem_rdata <= w;
  end

  // reference model: checks every cycle, then advances its own view of the next cycle
  always @(negedge clk) begin
    bit e_if, e_dm;
    int idx;
    if (!rst_n) begin
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_dm_gnt", bus.dm_gnt, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_dm_rvalid", bus.dm_rvalid, 0);
      chk("rst_w_mask", bus.mem_w_mask, 0);
      streak_m = 0;
      pend_if = 0;
      pend_dm = 0;
    end else begin
      e_if = bus.if_req && (!bus.dm_req || streak_m == LIM);
      e_dm = bus.dm_req && !e_if;
      chk("m_if_gnt", bus.if_gnt, e_if);
      chk("m_dm_gnt", bus.dm_gnt, e_dm);
      chk("m_w_mask", bus.mem_w_mask, e_dm ? bus.dm_wmask : 8'h00);
      chk("m_addr", bus.mem_addr, e_dm ? bus.dm_addr : bus.if_addr);
      chk("m_wdata", bus.mem_wdata, bus.dm_wdata);
      chk("m_if_rvalid", bus.if_rvalid, pend_if);
      chk("m_dm_rvalid", bus.dm_rvalid, pend_dm);
      if (pend_if) chk("m_if_rdata", bus.if_rdata, pend_data);
      if (pend_dm) chk("m_dm_rdata", bus.dm_rdata, pend_data);
      idx = e_dm ? int'(bus.dm_addr[15:3]) : int'(bus.if_addr[15:3]);
      if (e_dm)
        for (int b = 0; b < 8; b++)
          if (bus.dm_wmask[b]) ref_mem[idx][8*b +: 8] = bus.dm_wdata[8*b +: 8];
      pend_if = e_if;
      pend_dm = e_dm && bus.dm_wmask == 8'h00;
      pend_data = ref_mem[idx];
      streak_m = (!bus.if_req || e_if) ? 0 : (e_dm && streak_m < LIM) ? streak_m + 1 : streak_m;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp_w [4];
    exp_w[0] = 64'hA0000000_50000000;
    exp_w[1] = 64'hA0000001_50000001;
    exp_w[2] = 64'hA0000002_50000002;
    exp_w[3] = 64'hA0000003_50000003;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = word(i);
      ref_mem[i] = word(i);
    end
    bus.if_req = 1'b1;
    bus.if_addr = '0;
    bus.dm_req = 1'b0;
    bus.dm_addr = '0;
    bus.dm_wmask = '0;
    bus.dm_wdata = '0;
    @(negedge clk);
    chk("reset_gnt_blocked", bus.if_gnt, 0);
    step();
    bus.if_req = 1'b0;
    rst_n = 1'b1;
    // 1: reset mid-load discards the read
    step();
    bus.dm_req = 1'b1;
    bus.dm_addr = 16'h0040;
    @(negedge clk);
    chk("t1_dm_gnt", bus.dm_gnt, 1);
    #1;
    rst_n = 1'b0;
    bus.dm_req = 1'b0;
    @(negedge clk);
    chk("t1_dm_rvalid_in_rst", bus.dm_rvalid, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_dm_rvalid_after", bus.dm_rvalid, 0);
    // 2: fetch only, back-to-back
    for (int i = 0; i < 5; i++) begin
      step();
      bus.if_req = i < 4;
      bus.if_addr = 16'(i * 8);
      @(negedge clk);
      if (i < 4) chk("t2_if_gnt", bus.if_gnt, 1);
      if (i > 0) begin
        chk("t2_if_rvalid", bus.if_rvalid, 1);
        chk("t2_if_rdata", bus.if_rdata, exp_w[i-1]);
      end
    end
    // 3: contention pattern
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0010;
    bus.dm_req = 1'b1;
    bus.dm_addr = 16'h0080;
    bus.dm_wmask = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat = {pat, bus.dm_gnt ? "D" : (bus.if_gnt ? "I" : "-")};
      step();
    end
    total++;
    if (pat != "DDDDIDDDDI") begin
      bad++;
      $display("FAIL t3_pattern: got %s expected DDDDIDDDDI", pat);
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    // 4: store then load, write-first
    step();
    bus.dm_req = 1'b1;
    bus.dm_addr = 16'h0100;
    bus.dm_wmask = 8'h0F;
    bus.dm_wdata = 64'h11223344_55667788;
    @(negedge clk);
    chk("t4_store_gnt", bus.dm_gnt, 1);
    chk("t4_store_mask", bus.mem_w_mask, 64'h0F);
    step();
    bus.dm_wmask = 8'h00;
    @(negedge clk);
    chk("t4_no_store_rvalid", bus.dm_rvalid, 0);
    step();
    bus.dm_req = 1'b0;
    @(negedge clk);
    chk("t4_load_rvalid", bus.dm_rvalid, 1);
    chk("t4_load_rdata", bus.dm_rdata, 64'hA0000020_55667788);
    // 5: write-mask isolation
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0018;
    bus.dm_req = 1'b1;
    bus.dm_addr = 16'h0108;
    bus.dm_wmask = 8'hF0;
    bus.dm_wdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    chk("t5_dm_gnt", bus.dm_gnt, 1);
    chk("t5_w_mask", bus.mem_w_mask, 64'hF0);
    step();
    bus.dm_req = 1'b0;
    @(negedge clk);
    chk("t5_if_gnt", bus.if_gnt, 1);
    chk("t5_w_mask_if", bus.mem_w_mask, 64'h00);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("t5_if_rvalid", bus.if_rvalid, 1);
    chk("t5_dm_rvalid", bus.dm_rvalid, 0);
    chk("t5_if_rdata", bus.if_rdata, 64'hA0000003_50000003);
    // 6: dropped request while IF is forced
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0020;
    bus.dm_req = 1'b1;
    bus.dm_addr = 16'h0048;
    bus.dm_wmask = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_dm_streak_gnt", bus.dm_gnt, 1);
      step();
    end
    bus.dm_addr = 16'h0200;
    bus.dm_wmask = 8'hFF;
    bus.dm_wdata = '1;
    @(negedge clk);
    chk("t6_dm_dropped", bus.dm_gnt, 0);
    chk("t6_if_forced", bus.if_gnt, 1);
    chk("t6_w_mask", bus.mem_w_mask, 64'h00);
    step();
    bus.dm_req = 1'b0;
    bus.if_req = 1'b0;
    step();
    bus.dm_req = 1'b1;
    bus.dm_wmask = 8'h00;
    @(negedge clk);
    chk("t6_load_gnt", bus.dm_gnt, 1);
    step();
    bus.dm_req = 1'b0;
    @(negedge clk);
    chk("t6_unchanged", bus.dm_rdata, 64'hA0000040_50000040);
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
